// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode encodings, the control FSM state type and a small
// helper that classifies opcodes as shifts.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift opcodes take the iterative path through the FSM.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/adder_n.sv
// Width-generic ripple-carry adder.
// Ports:
//   cin  - carry into bit 0
//   a, b - WIDTH-bit addends
//   s    - WIDTH-bit sum
//   cout - carry out of the top bit
module adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Handshaked, parametrised ALU for the execute stage.
// Add/sub/logic results are registered with one cycle of latency; shifts
// move one bit position per cycle, so a result is ready max(1, shamt)
// cycles after acceptance. Each result is held with its flags until the
// consumer takes it.
// Ports:
//   clk, rst             - clock (rising edge), async active-high reset
//   in_valid, in_ready   - operand handshake (ready only in IDLE)
//   rs1, rs2, ctrl       - operand A, operand B / shift amount, opcode
//   out_valid, out_ready - result handshake
//   out                  - result
//   overflow             - adder carry-out for add/sub, else 0
//   zero                 - result is all zeros
//   illegal              - opcode was 3'b111
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  state_t             state, state_n;
  logic [WIDTH-1:0]   out_n;
  logic               overflow_n, zero_n, illegal_n;
  logic [WIDTH-1:0]   acc, acc_n;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic [2:0]         op, op_n;

  logic [SHAMT_W-1:0] shamt;
  logic               add_cin, add_cout;
  logic [WIDTH-1:0]   add_b, add_s;
  logic [WIDTH-1:0]   first_shift, step_shift;

  // One-bit shift step shared by the acceptance cycle and the SHIFT state.
  function automatic logic [WIDTH-1:0] shift_one(input logic [2:0] sop,
                                                 input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (sop)
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {v[WIDTH-2:0], 1'b0};
    endcase
    return r;
  endfunction

  assign shamt = rs2[SHAMT_W-1:0];

  // Subtraction reuses the single adder as rs1 + ~rs2 + 1.
  assign add_cin = (ctrl == OP_SUB);
  assign add_b   = add_cin ? ~rs2 : rs2;

  adder_n #(.WIDTH(WIDTH)) u_adder (
    .cin  (add_cin),
    .a    (rs1),
    .b    (add_b),
    .s    (add_s),
    .cout (add_cout)
  );

  assign first_shift = shift_one(ctrl, rs1);
  assign step_shift  = shift_one(op, acc);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Result, flag and shifter registers; reset clears any partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      op       <= OP_ADD;
    end else begin
      out      <= out_n;
      overflow <= overflow_n;
      zero     <= zero_n;
      illegal  <= illegal_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      op       <= op_n;
    end
  end

  // Next-state and datapath update. The first shift step happens in the
  // acceptance cycle so a shift by N presents its result after N cycles,
  // the same as a single-cycle op when N is 1.
  always_comb begin
    state_n    = state;
    out_n      = out;
    overflow_n = overflow;
    zero_n     = zero;
    illegal_n  = illegal;
    acc_n      = acc;
    cnt_n      = cnt;
    op_n       = op;

    case (state)
      IDLE: begin
        if (in_valid) begin
          op_n       = ctrl;
          overflow_n = 1'b0;
          illegal_n  = 1'b0;
          state_n    = DONE;
          if (is_shift_op(ctrl)) begin
            if (shamt == '0) begin
              out_n = rs1;
            end else if (shamt == SHAMT_W'(1)) begin
              out_n = first_shift;
            end else begin
              acc_n   = first_shift;
              cnt_n   = shamt - SHAMT_W'(1);
              state_n = SHIFT;
            end
          end else begin
            case (ctrl)
              OP_ADD, OP_SUB: begin
                out_n      = add_s;
                overflow_n = add_cout;
              end
              OP_NOR:  out_n = ~(rs1 | rs2);
              OP_NAND: out_n = ~(rs1 & rs2);
              default: begin
                out_n     = '0;
                illegal_n = 1'b1;
              end
            endcase
          end
          zero_n = (out_n == '0);
        end
      end

      SHIFT: begin
        acc_n = step_shift;
        cnt_n = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          out_n   = step_shift;
          zero_n  = (step_shift == '0);
          state_n = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized
// operations, checked by a scoreboard against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1, rs2;
  logic [2:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             overflow, zero, illegal;

  alu_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ov;
    logic             zr;
    logic             ill;
    int               acc_cyc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference model: results straight from the arithmetic meaning of each op.
  function automatic exp_t model(input logic [2:0] op,
                                 input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH:0] wide;
    int s;
    s     = int'(b) % (1 << SHAMT_W);
    e.ov  = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[WIDTH-1:0];
        e.ov  = wide[WIDTH];
      end
      OP_SUB: begin
        e.res = a - b;
        e.ov  = (a >= b);
      end
      OP_SRL:  e.res = a >> s;
      OP_SRA:  e.res = $signed(a) >>> s;
      OP_SLL:  e.res = a << s;
      OP_NOR:  e.res = ~(a | b);
      OP_NAND: e.res = ~(a & b);
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    if ((op == OP_SRL || op == OP_SRA || op == OP_SLL) && s > 0) e.lat = s;
    e.zr = (e.res == '0);
    return e;
  endfunction

  // Monitor: each new result is popped from the scoreboard and compared,
  // including how many cycles after acceptance it appeared.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_result: got out=0x%0h, required no result (cycle %0d)",
                   out, cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("out",      32'(out),      32'(mon_e.res));
          checkOutput("overflow", 32'(overflow), 32'(mon_e.ov));
          checkOutput("zero",     32'(zero),     32'(mon_e.zr));
          checkOutput("illegal",  32'(illegal),  32'(mon_e.ill));
          checkOutput("latency",  32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat - 1));
        end
      end
      prev_valid = out_valid;
    end
  end

  // Issue one operation once the DUT is ready and record its expectation.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit rand_ready);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, required 1 (cycle %0d)", cyc);
      return;
    end
    ctrl     = op;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e         = model(op, a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    rs1      = WIDTH'($urandom);
    rs2      = WIDTH'($urandom);
  endtask

  task automatic waitDrain();
    int w = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((sb.size() != 0 || !in_ready) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || !in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending, required 0 (cycle %0d)",
               sb.size(), cyc);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, required finish (cycle %0d)", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int wv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    rs1       = '0;
    rs2       = '0;
    ctrl      = OP_ADD;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out",       32'(out),       32'd0);
    checkOutput("rst_flags",     32'({overflow, zero, illegal}), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed add/sub");
    applyStimulus(OP_ADD, 8'hF0, 8'h20, 0);
    applyStimulus(OP_SUB, 8'h05, 8'h05, 0);
    applyStimulus(OP_SUB, 8'h03, 8'h05, 0);

    $display("[TB] directed shifts");
    applyStimulus(OP_SRL, 8'h80, 8'h07, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
    end
    applyStimulus(OP_SRA, 8'h80, 8'h03, 0);
    applyStimulus(OP_SRA, 8'h80, 8'h07, 0);
    applyStimulus(OP_SLL, 8'h81, 8'h01, 0);
    applyStimulus(OP_SLL, 8'h5A, 8'h08, 0);
    applyStimulus(OP_ILL, 8'h12, 8'h34, 0);
    waitDrain();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(OP_NOR, 8'h0F, 8'hF0, 0);
    wv = 0;
    @(negedge clk);
    while (!out_valid && wv < 5) begin
      @(negedge clk);
      wv++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid",    32'(out_valid), 32'd1);
      checkOutput("hold_out",      32'(out),       32'd0);
      checkOutput("hold_zero",     32'(zero),      32'd1);
      checkOutput("hold_in_ready", 32'(in_ready),  32'd0);
      in_valid = ~in_valid;
      rs1      = WIDTH'($urandom);
      rs2      = WIDTH'($urandom);
      ctrl     = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready",  32'(in_ready),  32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-shift");
    applyStimulus(OP_SRL, 8'hAB, 8'h06, 0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out",       32'(out),       32'd0);
    checkOutput("abort_flags",     32'({overflow, zero, illegal}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(OP_ADD, 8'h01, 8'h01, 0);
    waitDrain();

    $display("[TB] randomized operations");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom), 1);
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
